// File: rtl/nios_fprint_oci_pkg.sv
// ---------------------------------------------------------------------------
// nios_fprint_oci_pkg
// Shared definitions for the OCI debug-capture-trace (DCT) capture block:
//   - state_t      : capture/test-end sequencer states (RUN/FLUSH/DRAIN/DONE)
//   - entry_width  : width of one FIFO entry, {count, buffer}
//   - is_pow2      : FIFO depth legality check (power of two, at least 2)
// ---------------------------------------------------------------------------
package nios_fprint_oci_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int entry_width(input int cnt_w, input int dct_w);
        return cnt_w + dct_w;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/nios_fprint_oci_dct_fifo.sv
// ---------------------------------------------------------------------------
// nios_fprint_oci_dct_fifo
// Synchronous FIFO holding captured DCT frames.
//   clk, reset     : clock, synchronous active-high reset
//   push, push_data: write request and entry
//   pop_data       : oldest entry (zero while empty)
//   pop_valid      : FIFO non-empty
//   pop_ready      : consumer takes pop_data this cycle
//   level          : occupancy, 0..DEPTH
//   drop           : push refused because the FIFO is full and not popping
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module nios_fprint_oci_dct_fifo
    import nios_fprint_oci_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic empty;
    logic full;
    logic pop_fire;
    logic push_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_fire = pop_valid && pop_ready;
    // Pop-first: a pop in the same cycle frees the slot the push needs.
    assign push_ok  = push && (!full || pop_fire);
    assign drop     = push && full && !pop_fire;

    assign pop_valid = !empty;
    assign pop_data  = empty ? '0 : mem[rd_ptr];
    assign level     = count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count alone decides
    // which entries are live, and the empty gate above hides stale data.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/nios_fprint_oci_dct_capture.sv
// ---------------------------------------------------------------------------
// nios_fprint_oci_dct_capture
// Captures completed (wrapped) and flushed DCT trace frames into a FIFO and
// sequences the end-of-test handshake.
//   clk, reset      : clock, synchronous active-high reset
//   dct_buffer      : packed trace frame under construction
//   dct_count       : valid slots in dct_buffer
//   test_ending     : level; a rising edge requests a partial-frame flush
//   test_has_ended  : level; producer stopped
//   out_data        : {count, buffer} of the oldest entry
//   out_valid       : FIFO non-empty
//   out_ready       : consumer accepts out_data
//   fill_level      : FIFO occupancy
//   overflow        : sticky frame-dropped flag
//   overflow_count  : saturating dropped-frame counter
//   state           : RUN=0, FLUSH=1, DRAIN=2, DONE=3
//   test_done       : FIFO drained after test_has_ended
// ---------------------------------------------------------------------------
module nios_fprint_oci_dct_capture
    import nios_fprint_oci_pkg::*;
#(
    parameter int DCT_W = 30,
    parameter int CNT_W = 4,
    parameter int DEPTH = 16,
    parameter int OVF_W = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [DCT_W-1:0]                       dct_buffer,
    input  logic [CNT_W-1:0]                       dct_count,
    input  logic                                   test_ending,
    input  logic                                   test_has_ended,
    output logic [entry_width(CNT_W, DCT_W)-1:0]   out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [$clog2(DEPTH):0]                 fill_level,
    output logic                                   overflow,
    output logic [OVF_W-1:0]                       overflow_count,
    output logic [1:0]                             state,
    output logic                                   test_done
);

    localparam int ENTRY_W = entry_width(CNT_W, DCT_W);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end

    state_t             cur_state;
    logic [CNT_W-1:0]   prev_count;
    logic [DCT_W-1:0]   prev_buffer;
    logic               test_ending_d;

    logic               wrap_hit;
    logic               flush_hit;
    logic               push;
    logic [ENTRY_W-1:0] push_data;
    logic               drop;

    // A frame completes when the fill count falls back to zero; the frame
    // content is what was registered the cycle before.
    assign wrap_hit  = (cur_state == ST_RUN) && (prev_count != '0) && (dct_count == '0);
    // The flush takes whatever partial frame is live during the FLUSH cycle.
    assign flush_hit = (cur_state == ST_FLUSH) && (dct_count != '0);
    assign push      = wrap_hit || flush_hit;
    assign push_data = flush_hit ? {dct_count, dct_buffer} : {prev_count, prev_buffer};

    assign state = cur_state;

    nios_fprint_oci_dct_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop_data  (out_data),
        .pop_valid (out_valid),
        .pop_ready (out_ready),
        .level     (fill_level),
        .drop      (drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state     <= ST_RUN;
            test_done     <= 1'b0;
            prev_count    <= '0;
            prev_buffer   <= '0;
            test_ending_d <= 1'b0;
        end else begin
            prev_count    <= dct_count;
            prev_buffer   <= dct_buffer;
            test_ending_d <= test_ending;
            case (cur_state)
                ST_RUN: begin
                    if (test_ending && !test_ending_d) cur_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    cur_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (test_has_ended && (fill_level == '0)) begin
                        cur_state <= ST_DONE;
                        test_done <= 1'b1;
                    end
                end
                default: begin
                    // DONE is terminal until reset.
                    cur_state <= ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_count != '1) overflow_count <= overflow_count + 1'b1;
        end
    end

endmodule
